pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives the PC write enable and the enable/squash controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch flushes, instruction/data memory stalls and halt draining.
- Keeps a saturating stall-cycle counter and a data-memory timeout error flag.

---
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush,
// memory stalls, halt draining, stall-cycle counting and data-memory timeout.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  idRs,
  input  logic [2:0]  idRt,
  input  logic        idUsesRs,
  input  logic        idUsesRt,
  input  logic        exMemRead,
  input  logic [2:0]  exWriteRegSel,
  input  logic        brTaken,
  input  logic        imemStall,
  input  logic        dmemStall,
  input  logic        haltMem,
  output logic        enPC,
  output logic        en_IF_ID,
  output logic        en_ID_EX,
  output logic        en_EX_MEM,
  output logic        en_MEM_WB,
  output logic        flush_IF_ID,
  output logic        bubble_ID_EX,
  output logic        halted,
  output logic        memErr,
  output logic [15:0] stallCycles
);

  localparam int unsigned CntW   = 8;
  localparam int unsigned StallW = 16;

  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

  state_t            state, stateNext;
  logic [CntW-1:0]   waitCnt, waitCntNext;
  logic              memErrNext;
  logic              loadUse;
  logic              stallInc;

  assign loadUse = exMemRead &
                   ((idUsesRs & (idRs == exWriteRegSel)) |
                    (idUsesRt & (idRt == exWriteRegSel)));

  // HALTED cycles are idle time, not stalls
  assign stallInc = (state != HALTED) & ~enPC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      waitCnt     <= '0;
      memErr      <= 1'b0;
      stallCycles <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      memErr  <= memErrNext;
      if (stallInc && (stallCycles != {StallW{1'b1}}))
        stallCycles <= stallCycles + StallW'(1);
    end
  end

  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    memErrNext   = memErr;
    enPC         = 1'b1;
    en_IF_ID     = 1'b1;
    en_ID_EX     = 1'b1;
    en_EX_MEM    = 1'b1;
    en_MEM_WB    = 1'b1;
    flush_IF_ID  = 1'b0;
    bubble_ID_EX = 1'b0;
    halted       = 1'b0;

    if (rst) begin
      stateNext   = RUN;
      waitCntNext = '0;
      memErrNext  = 1'b0;
    end else begin
      case (state)
        RUN, MEMWAIT: begin
          waitCntNext = '0;
          if (dmemStall) begin
            {enPC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB} = 5'b00000;
            waitCntNext = waitCnt + CntW'(1);
            stateNext   = MEMWAIT;
            if (waitCnt == CntW'(MEM_TIMEOUT - 1)) begin
              memErrNext = 1'b1;
              stateNext  = HALTED;
            end
          end else if (haltMem) begin
            // retire the HALT, squash everything younger
            enPC         = 1'b0;
            en_EX_MEM    = 1'b0;
            flush_IF_ID  = 1'b1;
            bubble_ID_EX = 1'b1;
            stateNext    = DRAIN;
          end else begin
            stateNext = RUN;
            if (brTaken) begin
              flush_IF_ID  = 1'b1;
              bubble_ID_EX = 1'b1;
            end else if (loadUse) begin
              enPC         = 1'b0;
              en_IF_ID     = 1'b0;
              bubble_ID_EX = 1'b1;
            end else if (imemStall) begin
              enPC        = 1'b0;
              flush_IF_ID = 1'b1;
            end
          end
        end
        DRAIN: begin
          {enPC, en_IF_ID, en_ID_EX, en_EX_MEM} = 4'b0000;
          waitCntNext = '0;
          stateNext   = HALTED;
        end
        HALTED: begin
          {enPC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB} = 5'b00000;
          halted = 1'b1;
        end
        default: stateNext = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand sequences for the
// multi-cycle cases, then random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic       rst;
    logic [2:0] idRs;
    logic [2:0] idRt;
    logic       idUsesRs;
    logic       idUsesRt;
    logic       exMemRead;
    logic [2:0] exWriteRegSel;
    logic       brTaken;
    logic       imemStall;
    logic       dmemStall;
    logic       haltMem;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [7:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  idRs, idRt, exWriteRegSel;
  logic        idUsesRs, idUsesRt, exMemRead, brTaken, imemStall, dmemStall, haltMem;
  logic        enPC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
  logic        flush_IF_ID, bubble_ID_EX, halted, memErr;
  logic [15:0] stallCycles;
  logic [7:0]  outVec;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .exMemRead(exMemRead),
    .exWriteRegSel(exWriteRegSel), .brTaken(brTaken), .imemStall(imemStall),
    .dmemStall(dmemStall), .haltMem(haltMem), .enPC(enPC), .en_IF_ID(en_IF_ID),
    .en_ID_EX(en_ID_EX), .en_EX_MEM(en_EX_MEM), .en_MEM_WB(en_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .bubble_ID_EX(bubble_ID_EX), .halted(halted),
    .memErr(memErr), .stallCycles(stallCycles)
  );

  assign outVec = {enPC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
                   flush_IF_ID, bubble_ID_EX, halted};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: how long memory has been stalled, drain/halt flags, counters
  int frozen   = 0;
  bit draining = 0;
  bit isHalted = 0;
  bit err      = 0;
  int stalls   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] expOut(input stim_t s);
    bit lu;
    lu = s.exMemRead && ((s.idUsesRs && s.idRs == s.exWriteRegSel) ||
                         (s.idUsesRt && s.idRt == s.exWriteRegSel));
    if (s.rst)            return 8'b1111_1000;
    if (isHalted)         return 8'b0000_0001;
    if (draining)         return 8'b0000_1000;
    if (s.dmemStall)      return 8'b0000_0000;
    if (s.haltMem)        return 8'b0110_1110;
    if (s.brTaken)        return 8'b1111_1110;
    if (lu)               return 8'b0011_1010;
    if (s.imemStall)      return 8'b0111_1100;
    return 8'b1111_1000;
  endfunction

  task automatic advance(input stim_t s, input logic [7:0] e);
    if (s.rst) begin
      frozen = 0; draining = 0; isHalted = 0; err = 0; stalls = 0;
    end else if (!isHalted) begin
      if (!e[7] && stalls < 65535) stalls++;
      if (draining) begin
        draining = 0;
        isHalted = 1;
      end else if (s.dmemStall) begin
        frozen++;
        if (frozen >= TO) begin
          err = 1;
          isHalted = 1;
        end
      end else begin
        frozen = 0;
        if (s.haltMem) draining = 1;
      end
    end
  endtask

  // drive at negedge, check just after, model steps across the next edge
  task automatic step(input stim_t s, input string tag);
    logic [7:0] e;
    @(negedge clk);
    rst = s.rst; idRs = s.idRs; idRt = s.idRt; idUsesRs = s.idUsesRs;
    idUsesRt = s.idUsesRt; exMemRead = s.exMemRead; exWriteRegSel = s.exWriteRegSel;
    brTaken = s.brTaken; imemStall = s.imemStall; dmemStall = s.dmemStall;
    haltMem = s.haltMem;
    #1;
    e = expOut(s);
    chk({tag, ".out"}, 32'(outVec), 32'(e));
    chk({tag, ".stallCycles"}, 32'(stallCycles), 32'(stalls));
    chk({tag, ".memErr"}, 32'(memErr), 32'(err));
    advance(s, e);
  endtask

  function automatic stim_t mk(bit r, bit lu, bit br, bit im, bit dm, bit hl);
    stim_t s;
    s = '0;
    s.rst = r;
    if (lu) begin
      s.exMemRead = 1'b1; s.exWriteRegSel = 3'd3; s.idRt = 3'd3; s.idUsesRt = 1'b1;
    end
    s.brTaken = br; s.imemStall = im; s.dmemStall = dm; s.haltMem = hl;
    return s;
  endfunction

  vec_t  tbl[12];
  stim_t idle, rstS, s;
  int    burst;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0);
    rstS = mk(1, 0, 0, 0, 0, 0);

    tbl[0]  = '{idle,                  8'b1111_1000};
    tbl[1]  = '{mk(0, 1, 0, 0, 0, 0),  8'b0011_1010};
    s = idle; s.exMemRead = 1; s.exWriteRegSel = 5; s.idRs = 5; s.idUsesRs = 1;
    tbl[2]  = '{s,                     8'b0011_1010};
    s = mk(0, 1, 0, 0, 0, 0); s.idUsesRt = 0;
    tbl[3]  = '{s,                     8'b1111_1000};
    s = mk(0, 1, 0, 0, 0, 0); s.exMemRead = 0;
    tbl[4]  = '{s,                     8'b1111_1000};
    tbl[5]  = '{mk(0, 1, 1, 0, 0, 0),  8'b1111_1110};
    tbl[6]  = '{mk(0, 0, 0, 1, 0, 0),  8'b0111_1100};
    tbl[7]  = '{mk(0, 0, 1, 1, 0, 0),  8'b1111_1110};
    tbl[8]  = '{mk(0, 1, 0, 1, 0, 0),  8'b0011_1010};
    tbl[9]  = '{mk(0, 1, 1, 0, 0, 1),  8'b0110_1110};
    tbl[10] = '{mk(0, 0, 1, 0, 1, 1),  8'b0000_0000};
    tbl[11] = '{mk(1, 1, 0, 0, 1, 1),  8'b1111_1000};

    {rst, idRs, idRt, idUsesRs, idUsesRt, exMemRead, exWriteRegSel,
     brTaken, imemStall, dmemStall, haltMem} = rstS;
    repeat (2) @(posedge clk);

    step(idle, "resetState");

    foreach (tbl[i]) begin
      step(tbl[i].s, "tbl");
      chk($sformatf("tbl%0d.vec", i), 32'(outVec), 32'(tbl[i].exp));
      step(rstS, "tblRst");
    end

    // load-use lasts one cycle
    step(mk(0, 1, 0, 0, 0, 0), "lu");
    step(idle, "luAfter");
    chk("luOutAfter", 32'(outVec), 32'h0F8);
    chk("luStallCnt", 32'(stallCycles), 32'd1);

    // branch swallows load-use, no stall counted
    step(rstS, "r");
    step(mk(0, 1, 1, 0, 0, 0), "brLu");
    step(idle, "brLuAfter");
    chk("brLuStallCnt", 32'(stallCycles), 32'd0);

    // data-memory stall for 3 cycles
    step(rstS, "r");
    repeat (3) step(mk(0, 0, 0, 0, 1, 0), "dmem");
    step(idle, "dmemAfter");
    chk("dmemOutAfter", 32'(outVec), 32'h0F8);
    chk("dmemStallCnt", 32'(stallCycles), 32'd3);
    chk("dmemErr", 32'(memErr), 32'd0);

    // timeout after TO stall cycles, sticky until reset
    step(rstS, "r");
    repeat (TO) step(mk(0, 0, 0, 0, 1, 0), "to");
    step(mk(0, 0, 0, 0, 1, 0), "toHeld");
    chk("toHalted", 32'(halted), 32'd1);
    chk("toMemErr", 32'(memErr), 32'd1);
    step(idle, "toIdle");
    chk("toStillErr", 32'(memErr), 32'd1);
    step(rstS, "toRst");
    step(idle, "toCleared");
    chk("toClearedErr", 32'(memErr), 32'd0);
    chk("toClearedHalt", 32'(halted), 32'd0);

    // halt drain
    step(rstS, "r");
    step(mk(0, 0, 0, 0, 0, 1), "halt0");
    chk("halt0Out", 32'(outVec), 32'h06E);
    step(idle, "halt1");
    chk("halt1Out", 32'(outVec), 32'h008);
    step(idle, "halt2");
    chk("halt2Out", 32'(outVec), 32'h001);
    step(idle, "halt3");
    step(rstS, "haltRst");
    step(idle, "haltResumed");
    chk("haltResumedOut", 32'(outVec), 32'h0F8);

    // halt under memory stall
    step(rstS, "r");
    repeat (2) step(mk(0, 0, 0, 0, 1, 1), "hmFrozen");
    step(mk(0, 0, 0, 0, 0, 1), "hmSquash");
    step(idle, "hmDrain");
    step(idle, "hmHalted");
    chk("hmHaltedOut", 32'(outVec), 32'h001);
    chk("hmStallCnt", 32'(stallCycles), 32'd4);

    // random stimulus against the model
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.rst = ($urandom_range(0, 63) == 0);
      s.idRs = 3'($urandom_range(0, 7));
      s.idRt = 3'($urandom_range(0, 7));
      s.exWriteRegSel = 3'($urandom_range(0, 7));
      s.idUsesRs = 1'($urandom_range(0, 1));
      s.idUsesRt = 1'($urandom_range(0, 1));
      s.exMemRead = 1'($urandom_range(0, 1));
      s.brTaken = ($urandom_range(0, 4) == 0);
      s.imemStall = ($urandom_range(0, 4) == 0);
      s.haltMem = ($urandom_range(0, 29) == 0);
      if (burst == 0 && $urandom_range(0, 30) == 0) burst = $urandom_range(2, 6);
      s.dmemStall = (burst > 0) || ($urandom_range(0, 9) == 0);
      if (burst > 0) burst--;
      step(s, "rand");
    end
    step(idle, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
